// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin arbiter sharing one datapath controller among
// NUM_REQ requesters. Grants one requester, drives the controller start level,
// follows ctrl_done through a full job and returns a one-cycle ack to the winner.
// Optional feature macro: ARB_TIMEOUT_EN adds a watchdog that aborts a job
// after TIMEOUT_CYCLES cycles in START/RUN and pulses timeout_err.
// Reset port rst is asynchronous and active-low.
module datapath_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ctrl_done,
  output logic               start_signal,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy,
  output logic               timeout_err
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("datapath_arbiter: NUM_REQ must be 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("datapath_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("datapath_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_ACK
`ifdef ARB_TIMEOUT_EN
    , S_ABORT
`endif
  } state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [ID_W-1:0]   ptr_after;

  // Winner search: first set req bit scanning upward from ptr, wrapping at NUM_REQ-1.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Pointer moves to the requester after the current winner, wrapping to 0.
  assign ptr_after = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       to_expire;

  assign to_expire = (state == S_START || state == S_RUN) && (to_cnt == TO_LAST);

  // Watchdog counter: cleared on entry to START, counts every START/RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == S_IDLE) begin
      to_cnt <= '0;
    end else if (state == S_START || state == S_RUN) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`endif

  // Next-state logic for the job sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (win_found && ctrl_done) state_next = S_START;
      S_START: if (!ctrl_done) state_next = S_RUN;
      S_RUN:   if (ctrl_done) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
`ifdef ARB_TIMEOUT_EN
      S_ABORT: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    // Completion seen in RUN on the expiry cycle wins over the watchdog.
    if (to_expire && !(state == S_RUN && ctrl_done)) state_next = S_ABORT;
`endif
  end

  // State, grant, winner id and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (state_next == S_START) begin
            grant    <= NUM_REQ'(1) << win_id;
            grant_id <= win_id;
          end
        end
        S_ACK: begin
          grant <= '0;
          ptr   <= ptr_after;
        end
`ifdef ARB_TIMEOUT_EN
        S_ABORT: begin
          grant <= '0;
          ptr   <= ptr_after;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs are decoded only from registered state and grant.
  assign start_signal = (state == S_START);
  assign busy         = (state != S_IDLE);
  assign ack          = (state == S_ACK) ? grant : '0;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err  = (state == S_ABORT);
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: doc/datapath_arbiter.md
# datapath_arbiter

Round-robin arbiter that shares one datapath controller between up to `NUM_REQ` requesters. It grants the datapath to one requester at a time and drives the controller's `start_signal`. It tracks the controller's `done` level through a full job and returns a one-cycle `ack` to the winning requester. It sits directly above the controller in the hierarchy and is the only block allowed to drive its start input.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: width of `grant_id`; must equal `$clog2(NUM_REQ)`.
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles. Used only when `ARB_TIMEOUT_EN` is defined; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  `NUM_REQ`: level requests; bit i belongs to requester i.
- `ctrl_done`  in  1: controller `done` level; high while the controller is idle.
- `start_signal`  out  1: start level to the controller.
- `grant`  out  `NUM_REQ`: one-hot grant; all zero when no job is active.
- `grant_id`  out  `ID_W`: binary index of the current or last winner.
- `ack`  out  `NUM_REQ`: one-cycle completion pulse to the winner.
- `busy`  out  1: high in every state except IDLE.
- `timeout_err`  out  1: one-cycle pulse when the watchdog expires.

## Operation
States: IDLE, START, RUN, ACK, plus ABORT when `ARB_TIMEOUT_EN` is defined. State is registered.

- **IDLE**
  - If `|req` and `ctrl_done`=1, pick the winner and go to START.
  - The winner is the first set `req` bit scanning upward from `ptr` and wrapping at `NUM_REQ-1`.
  - `grant` and `grant_id` are registered on this transition.
  - If `ctrl_done`=0, stay in IDLE: the controller is not ready.
- **START**
  - `start_signal`=1 and `grant` is held.
  - Leave for RUN on the first sampled `ctrl_done`=0.
- **RUN**
  - `start_signal`=0.
  - Go to ACK on the first sampled `ctrl_done`=1.
- **ACK**
  - `ack[winner]`=1 for exactly this cycle; `grant` is still asserted.
  - Set `ptr`=(winner+1) mod `NUM_REQ`.
  - Go to IDLE; `grant` is all zero from the next cycle.
- **Request withdrawal:** dropping `req[winner]` after grant is ignored; the job runs to ACK.
- **Fairness:** a requester that holds `req` is granted within `NUM_REQ` jobs.
- **Pointer wrap:** a winner of `NUM_REQ-1` sets `ptr`=0.
- **Idle requester bits:** `req` bits other than the winner have no effect outside IDLE.
- **Reset values:** `ptr`=0, `grant`=0, `grant_id`=0, `ack`=0, `start_signal`=0, `busy`=0, `timeout_err`=0, state=IDLE. This applies immediately on `rst` low, including mid-job; the controller is reset by the same `rst`.

## Timing
- `req` sampled in IDLE at edge N gives `grant`/`busy`/`start_signal` high after edge N.
- `start_signal` stays high until the edge that samples `ctrl_done`=0, then drops after that edge.
- `ctrl_done` rising, sampled at edge M, gives `ack` high for the cycle after M.
- After ACK the arbiter is back in IDLE, so minimum turnaround between jobs is 1 idle cycle.
- Minimum job length is 4 cycles: START 1, RUN ≥1, ACK 1, IDLE 1.
- All outputs come from registers; there is no combinational path from input to output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to START and increments each cycle in START and RUN.
  - When it reaches `TIMEOUT_CYCLES`, go to ABORT.
  - ABORT: `timeout_err`=1 for one cycle, no `ack`, `ptr`=(winner+1) mod `NUM_REQ`, then IDLE with `grant` cleared.
  - If `ctrl_done` rises on the same cycle the counter expires, completion wins and ACK is taken.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; START and RUN wait indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Single request: `req`=0001 with a controller model (done low 3 cycles after start) → `grant`=0001, `start_signal` high 1+ cycles, `ack`=0001 one cycle, `ptr`=1.
- Contention: `req`=1111 held for 4 jobs → grant order 0001, 0010, 0100, 1000, then 0001 again (wrap).
- Withdrawal: grant requester 2, drop `req[2]` in RUN → job completes, `ack`=0100 still issued.
- Not ready: `ctrl_done`=0 with `req`=0010 → stays IDLE, `grant`=0; `ctrl_done`→1 → `grant`=0010 next cycle.
- Reset mid-RUN: `rst` low → `grant`, `start_signal`, `busy` all 0 asynchronously; after release, `req`=1000 is granted first scanning from `ptr`=0.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, controller never completes → `timeout_err` pulse after 10 cycles in START/RUN, no `ack`, next requester granted.
